// File: rtl/snake_pkg.sv
// Shared types for the snake LED grid: direction encoding, cell occupancy states
// and the direction-reversal helper used by entry detection.
package snake_pkg;

    localparam int DIR_N = 4;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        HEAD = 2'b01,
        BODY = 2'b10
    } cell_state_t;

    // The encoding is chosen so that reversing a direction is a bitwise invert.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/snake_entry_detect.sv
// Flags when a neighbouring head is about to move into this cell.
// Also used by the apple-placement logic.
module snake_entry_detect
    import snake_pkg::*;
(
    input  logic [3:0] nbr_head,
    input  logic [7:0] nbr_dir,
    output logic       entry
);

    // The neighbour on side s enters us when it heads back toward side s.
    always_comb begin
        entry = 1'b0;
        for (int s = 0; s < DIR_N; s++) begin
            if (nbr_head[s] && (nbr_dir[2*s +: 2] == opposite(dir_t'(2'(s))))) begin
                entry = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_cell.sv
// Per-LED occupancy cell: tracks head/body presence, remaining life in move
// steps, growth on apple steps, and a sticky self-collision flag.
module snake_cell
    import snake_pkg::*;
#(
    parameter int LEN_W      = 6,
    parameter int START_HEAD = 0,
    parameter int START_LEN  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_stb,
    input  logic             grow,
    input  logic             halt,
    input  logic             clear,
    input  logic             spawn,
    input  logic [LEN_W-1:0] length,
    input  logic [3:0]       nbr_head,
    input  logic [7:0]       nbr_dir,
    output logic             lit,
    output logic             is_head,
    output logic             collision,
    output logic [LEN_W-1:0] life
);

    cell_state_t      state_q, state_d;
    logic [LEN_W-1:0] life_q, life_d;
    logic             coll_q, coll_d;
    logic             entry;
    logic             step;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] nlife;

    snake_entry_detect u_entry (
        .nbr_head (nbr_head),
        .nbr_dir  (nbr_dir),
        .entry    (entry)
    );

    assign step    = move_stb & ~halt;
    assign len_eff = (length == '0) ? LEN_W'(1) : length;

    // Growth holds life rather than adding to it, so life can never exceed len_eff.
    always_comb begin
        if (grow || life_q == '0) nlife = life_q;
        else                      nlife = life_q - LEN_W'(1);
    end

    always_comb begin
        state_d = state_q;
        life_d  = life_q;
        coll_d  = coll_q;
        if (clear) begin
            state_d = OFF;
            life_d  = '0;
            coll_d  = 1'b0;
        end else if (spawn) begin
            state_d = HEAD;
            life_d  = len_eff;
        end else if (step) begin
            unique case (state_q)
                OFF: begin
                    if (entry) begin
                        state_d = HEAD;
                        life_d  = len_eff;
                    end
                end
                HEAD: begin
                    if (entry) begin
                        coll_d = 1'b1;
                        life_d = len_eff;
                    end else if (nlife != '0) begin
                        state_d = BODY;
                        life_d  = nlife;
                    end else begin
                        state_d = OFF;
                        life_d  = '0;
                    end
                end
                BODY: begin
                    if (entry) begin
                        // A tail leaving on this very step frees the cell for the head.
                        if (!(life_q == LEN_W'(1) && !grow)) coll_d = 1'b1;
                        state_d = HEAD;
                        life_d  = len_eff;
                    end else if (nlife != '0) begin
                        life_d = nlife;
                    end else begin
                        state_d = OFF;
                        life_d  = '0;
                    end
                end
                default: begin
                    state_d = OFF;
                    life_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (START_HEAD != 0) ? HEAD : OFF;
            life_q  <= (START_HEAD != 0) ? LEN_W'(START_LEN) : '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
            coll_q  <= coll_d;
        end
    end

    assign lit       = (state_q != OFF);
    assign is_head   = (state_q == HEAD);
    assign collision = coll_q;
    assign life      = life_q;

endmodule

// File: doc/snake_cell.md
Name: snake_cell

Overview:
Parametrised per-cell occupancy engine for the snake LED grid; one instance sits behind each matrix LED.
- Tracks whether the snake body covers the cell, and whether the cell is the head.
- Holds a remaining-life count in move steps, honours growth when an apple is eaten, and flags self-collision.
- Replaces fixed-width, tick-based lifetime cells with a move-strobe-driven, width-generic cell with spawn/clear/halt control.

Parameters:
LEN_W, 6, width of snake length and life counter
START_HEAD, 0, 1 = cell enters HEAD with life=START_LEN on reset (spawn cell)
START_LEN, 3, initial life when START_HEAD=1 (must be 1..2^LEN_W-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
move_stb  in  1  one-cycle pulse: snake advances one step
grow  in  1  qualifies move_stb: apple eaten this step, tail does not retract
halt  in  1  game over/pause: move_stb ignored while high
clear  in  1  synchronous board clear
spawn  in  1  force cell to HEAD with life=length
length  in  LEN_W  current snake length (0 treated as 1)
nbr_head  in  4  neighbour on side s (index = dir_t) is head
nbr_dir  in  8  2-bit next direction of each neighbour, slice s = bits [2s+1:2s]
lit  out  1  body or head present (drives LED)
is_head  out  1  cell is current head
collision  out  1  sticky: head entered occupied cell
life  out  LEN_W  remaining steps before cell goes dark

Behaviour:
- Direction encoding (dir_t): UP=00, LEFT=01, RIGHT=10, DOWN=11. opposite(d) = ~d.
- entry = OR over s of (nbr_head[s] & nbr_dir[s] == opposite(s)). The neighbour on side s moving toward this cell enters it.
- step = move_stb & !halt. len_eff = (length==0) ? 1 : length.
- States: OFF, HEAD, BODY.
- Reset values:
  - START_HEAD=0: state OFF, life 0, collision 0, lit 0, is_head 0.
  - START_HEAD=1: state HEAD, life START_LEN.
- Priority per edge: reset > clear > spawn > step > hold.
- clear: state OFF, life 0, collision 0.
- spawn: state HEAD, life len_eff, collision unchanged.
- No step: all registers hold. grow and entry are ignored.
- Retention on a step: nlife = grow ? life : life-1. If nlife==0, the cell goes OFF.
- OFF + step:
  - entry: go to HEAD, life=len_eff.
  - otherwise: stay OFF.
- HEAD + step:
  - entry: collision=1, HEAD, life=len_eff.
  - otherwise: apply retention; state becomes BODY if nlife>0, else OFF.
- BODY + step:
  - entry with life==1 and !grow (tail vacating this same step): HEAD, life=len_eff, no collision.
  - entry otherwise: collision=1, HEAD, life=len_eff.
  - no entry: apply retention; stay BODY if nlife>0, else OFF.
- life never underflows. It never exceeds len_eff, because grow holds life rather than incrementing it.
- Outputs are registered-state decodes with zero extra latency: lit=(state!=OFF), is_head=(state==HEAD).
- A step raises lit one cycle after the move_stb edge. A cell entered with length L stays lit for exactly L steps when no grow occurs.
- Multiple simultaneous nbr_head entries: treated as a single entry; the grid guarantees one head.
- Reset mid-operation discards life and collision immediately.

Decomposition:
- Package snake_pkg:
  - dir_t enum; cell_state_t {OFF, HEAD, BODY}
  - function opposite(dir_t)
  - constant DIR_N=4
- Sub-module snake_entry_detect: combinational.
  - Inputs nbr_head and nbr_dir; output entry.
  - Reused by the apple-placement logic.
- Rest: one always_comb next-state/next-life block plus one always_ff block, in snake_cell.

Test Plan:
- Basic trail: length=3, nbr_head[DOWN]=1 with nbr_dir slice DOWN=UP, one step → HEAD, life=3. Then steps without entry → BODY life 2, BODY life 1, then OFF. lit high for exactly 3 steps.
- Growth: enter with length=2, assert grow on the next step → life stays 2. Cell then needs 2 more steps to go OFF (3 steps lit total).
- Tail chase: cell BODY life=1, entry with grow=0 → HEAD, life=length, collision=0. Same case with grow=1 → collision=1, sticky through later steps until clear.
- Halt/priority: halt=1 with move_stb and entry → no change. spawn and move_stb in the same cycle with length=5 → HEAD, life=5. clear while collision=1 → OFF, collision=0.
- Wrong-direction neighbour: nbr_head[LEFT]=1 with nbr_dir slice LEFT=UP, step → cell stays OFF. length=0 entry → life=1, dark after 1 step.
- Reset mid-life: BODY life=4, reset → OFF, life 0. With START_HEAD=1, START_LEN=3 → HEAD, life 3 after reset.
